range_filter: RTL and testbench

- Parametrised successor to the fixed-window extract stage of the IoT data-filtering datapath.
- Assembles DATA_W-bit words from IN_W-bit serial beats, MSB slice first.
- Compares each word against runtime-programmable low/high bounds and emits passing words with a one-cycle valid pulse.
- Supports extract or exclude mode and inclusive or exclusive bounds; sits between the serial input port and the output mux.

---
 rtl/range_filter_pkg.sv | 30 +++
 rtl/range_filter_cmp.sv | 45 ++++
 rtl/range_filter.sv | 223 ++++++++++++++++++++++
 tb/tb_range_filter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/range_filter_pkg.sv
// range_filter_pkg
//   Shared definitions for the range_filter block and its comparator.
//   - state_e          : sequencing states (COLLECT, CMP, OUT)
//   - MODE_EXTRACT/EXCLUDE : cfg_mode encodings
//   - BOUND_*_FILL     : bit used to build the reset-time bounds
//                        (low = all zeros, high = all ones)
//   - beat_cnt_width() : width of the beat counter for a given beat count
package range_filter_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CMP     = 2'd1,
      ST_OUT     = 2'd2
   } state_e;

   localparam logic MODE_EXTRACT = 1'b0;
   localparam logic MODE_EXCLUDE = 1'b1;

   // Default window after reset covers the whole unsigned range.
   localparam logic BOUND_LOW_FILL  = 1'b0;
   localparam logic BOUND_HIGH_FILL = 1'b1;
   localparam logic MODE_DEFAULT    = MODE_EXTRACT;
   localparam logic INCL_DEFAULT    = 1'b0;

   // A single-beat word still needs a 1-bit counter to keep widths legal.
   function automatic int beat_cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/range_filter_cmp.sv
// range_cmp
//   Combinational word-versus-window comparator.
//   Ports:
//     word_i  [DATA_W] word under test (unsigned)
//     low_i   [DATA_W] lower bound
//     high_i  [DATA_W] upper bound
//     incl_i           1 = bounds inclusive, 0 = exclusive
//     mode_i           MODE_EXTRACT passes in-range words,
//                      MODE_EXCLUDE passes out-of-range words
//     pass_o           word should be forwarded
//   An inverted window (low > high, or low == high when exclusive) makes
//   in_range false for every word; no special casing is required because
//   the two-sided compare already yields that.
module range_cmp
   import range_filter_pkg::*;
#(
   parameter int DATA_W = 128
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [DATA_W-1:0] low_i,
   input  logic [DATA_W-1:0] high_i,
   input  logic              incl_i,
   input  logic              mode_i,
   output logic              pass_o
);

   logic above_low;
   logic below_high;
   logic in_range;

   always_comb begin
      above_low  = 1'b0;
      below_high = 1'b0;
      if (incl_i) begin
         above_low  = (word_i >= low_i);
         below_high = (word_i <= high_i);
      end else begin
         above_low  = (word_i > low_i);
         below_high = (word_i < high_i);
      end
      in_range = above_low && below_high;
      pass_o   = in_range ^ (mode_i == MODE_EXCLUDE);
   end

endmodule

// File: rtl/range_filter.sv
// range_filter
//   Assembles DATA_W-bit words from IN_W-bit serial beats (MSB slice first),
//   checks each word against a programmable window and emits passing words
//   with a one-cycle valid pulse.
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     in_en, iot_in   serial slice and its qualifier
//     cfg_we          load cfg_low/cfg_high/cfg_mode/cfg_incl into shadow
//     cfg_low/high    window bounds (unsigned)
//     cfg_mode        0 = extract (pass in range), 1 = exclude
//     cfg_incl        1 = inclusive bounds, 0 = exclusive
//     busy            slice offered this cycle would be dropped (CMP state)
//     valid, iot_out  passing word, iot_out is zero when valid is low
//   Optional feature (macro RANGE_FILTER_STATS_EN):
//     pass_cnt, drop_cnt [CNT_W] saturating counts of forwarded / dropped
//     words, cleared by rst and by cfg_we.
//   Handshake: a slice is consumed on a rising edge where in_en=1 and
//   busy=0; slices offered while busy=1 are discarded, never stalled.
//   Timing: last beat sampled at edge N -> CMP, decision registered at
//   edge N+1 -> OUT, valid/iot_out registered at edge N+2.
module range_filter
   import range_filter_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int IN_W   = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic [IN_W-1:0]   iot_in,
   input  logic              cfg_we,
   input  logic [DATA_W-1:0] cfg_low,
   input  logic [DATA_W-1:0] cfg_high,
   input  logic              cfg_mode,
   input  logic              cfg_incl,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] iot_out
`ifdef RANGE_FILTER_STATS_EN
   ,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  drop_cnt
`endif
);

   localparam int BEATS  = DATA_W / IN_W;
   localparam int BCNT_W = beat_cnt_width(BEATS);
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

   if (((DATA_W % IN_W) != 0) || (CNT_W < 1)) begin : g_param_check
      $error("range_filter: DATA_W must be a multiple of IN_W and CNT_W must be positive");
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [BCNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                pass_q, pass_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   out_q, out_d;

   // Shadow (written by cfg_we) and active (used by the comparator) config
   logic [DATA_W-1:0]   sh_low_q, sh_high_q;
   logic                sh_mode_q, sh_incl_q;
   logic [DATA_W-1:0]   act_low_q, act_high_q;
   logic                act_mode_q, act_incl_q;

   // Output-comb control signals
   logic                accept;
   logic                last_beat;
   logic                copy_cfg;
   logic                cmp_pass;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: if (last_beat) state_d = ST_CMP;
         ST_CMP:     state_d = ST_OUT;
         // A beat taken in OUT belongs to the next word; with one-beat
         // words it is also that word's last beat.
         ST_OUT:     state_d = last_beat ? ST_CMP : ST_COLLECT;
         default:    state_d = ST_COLLECT;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic
   // ------------------------------------------------------------------
   always_comb begin
      busy      = (state_q == ST_CMP);
      accept    = in_en && !busy;
      last_beat = accept && (cnt_q == LAST_BEAT);
      // Config may only change between words, so a word always sees the
      // config that was active at its first beat. The copy reads the
      // registered shadow, so a cfg_we in the same cycle lands next word.
      copy_cfg  = (cnt_q == '0) && (state_q != ST_CMP);
      valid_d   = (state_q == ST_OUT) && pass_q;
      out_d     = valid_d ? shift_q : '0;
   end

   // ------------------------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------------------------
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pass_d  = pass_q;
      if (accept) begin
         // Concatenate then keep the low DATA_W bits: new slice enters LSBs.
         shift_d = DATA_W'({shift_q, iot_in});
         cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
      end
      if (state_q == ST_CMP) begin
         pass_d = cmp_pass;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
         pass_q  <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pass_q  <= pass_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   // ------------------------------------------------------------------
   // Configuration shadow / active registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_low_q   <= {DATA_W{BOUND_LOW_FILL}};
         sh_high_q  <= {DATA_W{BOUND_HIGH_FILL}};
         sh_mode_q  <= MODE_DEFAULT;
         sh_incl_q  <= INCL_DEFAULT;
         act_low_q  <= {DATA_W{BOUND_LOW_FILL}};
         act_high_q <= {DATA_W{BOUND_HIGH_FILL}};
         act_mode_q <= MODE_DEFAULT;
         act_incl_q <= INCL_DEFAULT;
      end else begin
         if (cfg_we) begin
            sh_low_q  <= cfg_low;
            sh_high_q <= cfg_high;
            sh_mode_q <= cfg_mode;
            sh_incl_q <= cfg_incl;
         end
         if (copy_cfg) begin
            act_low_q  <= sh_low_q;
            act_high_q <= sh_high_q;
            act_mode_q <= sh_mode_q;
            act_incl_q <= sh_incl_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Comparator
   // ------------------------------------------------------------------
   range_cmp #(
      .DATA_W (DATA_W)
   ) u_cmp (
      .word_i (shift_q),
      .low_i  (act_low_q),
      .high_i (act_high_q),
      .incl_i (act_incl_q),
      .mode_i (act_mode_q),
      .pass_o (cmp_pass)
   );

   assign valid   = valid_q;
   assign iot_out = out_q;

`ifdef RANGE_FILTER_STATS_EN
   // ------------------------------------------------------------------
   // Saturating statistics; a config write starts a fresh measurement.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] pass_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else if (cfg_we) begin
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else if (state_q == ST_OUT) begin
         if (pass_q) begin
            if (!(&pass_cnt_q)) pass_cnt_q <= pass_cnt_q + 1'b1;
         end else begin
            if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_range_filter.sv
// tb_range_filter
//   Directed, table-driven bench for range_filter (DATA_W=128, IN_W=8).
//   Covers window compare in all mode/incl combinations, inverted and
//   degenerate windows, config shadowing at word boundaries, back-to-back
//   streaming with slices offered in CMP, mid-word reset, and (with
//   RANGE_FILTER_STATS_EN) the statistics counters including saturation.
module tb_range_filter;
   import range_filter_pkg::*;

   localparam int DATA_W = 128;
   localparam int IN_W   = 8;
   localparam int BEATS  = DATA_W / IN_W;

   localparam logic [DATA_W-1:0] L1   = {4'h6, {124{1'b1}}};
   localparam logic [DATA_W-1:0] H1   = {4'hA, {124{1'b1}}};
   localparam logic [DATA_W-1:0] X8   = {4'h8, 124'h0};
   localparam logic [DATA_W-1:0] X5   = {4'h5, 124'h0};
   localparam logic [DATA_W-1:0] X4   = {4'h4, 124'h0};
   localparam logic [DATA_W-1:0] LA   = {4'hA, 124'h0};
   localparam logic [DATA_W-1:0] H7   = {4'h7, 124'h0};
   localparam logic [DATA_W-1:0] ZERO = '0;
   localparam logic [DATA_W-1:0] ONES = '1;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              in_en;
   logic [IN_W-1:0]   iot_in;
   logic              cfg_we;
   logic [DATA_W-1:0] cfg_low, cfg_high;
   logic              cfg_mode, cfg_incl;
   logic              busy, valid;
   logic [DATA_W-1:0] iot_out;

   always #5 clk = ~clk;

`ifdef RANGE_FILTER_STATS_EN
   logic [15:0]       pass_cnt, drop_cnt;
   logic [1:0]        s_pass_cnt, s_drop_cnt;
   logic              s_busy, s_valid;
   logic [DATA_W-1:0] s_iot_out;
`endif

   range_filter #(.DATA_W(DATA_W), .IN_W(IN_W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in),
      .cfg_we(cfg_we), .cfg_low(cfg_low), .cfg_high(cfg_high),
      .cfg_mode(cfg_mode), .cfg_incl(cfg_incl),
      .busy(busy), .valid(valid), .iot_out(iot_out)
`ifdef RANGE_FILTER_STATS_EN
      , .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
`endif
   );

`ifdef RANGE_FILTER_STATS_EN
   range_filter #(.DATA_W(DATA_W), .IN_W(IN_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in),
      .cfg_we(cfg_we), .cfg_low(cfg_low), .cfg_high(cfg_high),
      .cfg_mode(cfg_mode), .cfg_incl(cfg_incl),
      .busy(s_busy), .valid(s_valid), .iot_out(s_iot_out),
      .pass_cnt(s_pass_cnt), .drop_cnt(s_drop_cnt)
   );
`endif

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic              mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && valid) got_q.push_back(iot_out);
   end

   task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic write_cfg(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi,
                            input logic mode, input logic incl);
      cfg_low = lo; cfg_high = hi; cfg_mode = mode; cfg_incl = incl;
      cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Drives beats first..first+n-1; cfg_we pulses on beat cfg_beat.
   task automatic send_beats(input logic [DATA_W-1:0] w, input int first, input int n, input int cfg_beat);
      for (int i = first; i < first + n; i++) begin
         in_en  = 1'b1;
         iot_in = w[DATA_W-1-i*IN_W -: IN_W];
         cfg_we = (i == cfg_beat);
         @(negedge clk);
      end
      in_en  = 1'b0;
      cfg_we = 1'b0;
   endtask

   // Full word then exact-latency check of the output pulse.
   task automatic check_word(input string name, input logic [DATA_W-1:0] w,
                             input logic exp_pass, input int cfg_beat);
      send_beats(w, 0, BEATS, cfg_beat);
      check({name, " busy in CMP"}, {{DATA_W{1'b0}}, busy}, {{DATA_W{1'b0}}, 1'b1});
      check({name, " idle in CMP"}, {valid, iot_out}, '0);
      @(negedge clk);
      check({name, " idle in OUT"}, {valid, iot_out}, '0);
      @(negedge clk);
      check({name, " result"}, {valid, iot_out}, {exp_pass, exp_pass ? w : ZERO});
      @(negedge clk);
      check({name, " pulse end"}, {valid, iot_out}, '0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [DATA_W-1:0] low;
      logic [DATA_W-1:0] high;
      logic              mode;
      logic              incl;
      logic [DATA_W-1:0] word;
      logic              exp_pass;
      string             name;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{L1, H1, MODE_EXTRACT, 1'b0, X8,   1'b1, "ext excl mid"};
      vecs[1]  = '{L1, H1, MODE_EXTRACT, 1'b0, L1,   1'b0, "ext excl eq low"};
      vecs[2]  = '{L1, H1, MODE_EXTRACT, 1'b0, H1,   1'b0, "ext excl eq high"};
      vecs[3]  = '{L1, H1, MODE_EXTRACT, 1'b1, L1,   1'b1, "ext incl eq low"};
      vecs[4]  = '{L1, H1, MODE_EXTRACT, 1'b1, H1,   1'b1, "ext incl eq high"};
      vecs[5]  = '{L1, H1, MODE_EXCLUDE, 1'b1, X5,   1'b1, "exc incl below"};
      vecs[6]  = '{L1, H1, MODE_EXCLUDE, 1'b1, X8,   1'b0, "exc incl mid"};
      vecs[7]  = '{LA, H7, MODE_EXTRACT, 1'b0, X8,   1'b0, "ext inverted"};
      vecs[8]  = '{LA, H7, MODE_EXCLUDE, 1'b0, X8,   1'b1, "exc inverted"};
      vecs[9]  = '{X8, X8, MODE_EXTRACT, 1'b1, X8,   1'b1, "ext incl point"};
      vecs[10] = '{X8, X8, MODE_EXTRACT, 1'b0, X8,   1'b0, "ext excl point"};
      vecs[11] = '{X8, X8, MODE_EXCLUDE, 1'b0, X5,   1'b1, "exc excl point"};
      vecs[12] = '{ZERO, ONES, MODE_EXTRACT, 1'b0, ZERO, 1'b0, "ext excl zero"};
      vecs[13] = '{ZERO, ONES, MODE_EXTRACT, 1'b1, ZERO, 1'b1, "ext incl zero"};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; in_en = 1'b0; iot_in = '0; cfg_we = 1'b0;
      cfg_low = '0; cfg_high = '0; cfg_mode = 1'b0; cfg_incl = 1'b0;
      repeat (2) @(negedge clk);
      check("reset outputs", {busy, valid, iot_out}, '0);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset outputs", {busy, valid, iot_out}, '0);

      // Table of window cases
      foreach (vecs[i]) begin
         write_cfg(vecs[i].low, vecs[i].high, vecs[i].mode, vecs[i].incl);
         check_word(vecs[i].name, vecs[i].word, vecs[i].exp_pass, -1);
      end

      // cfg_we mid-word: word k keeps old window, word k+1 sees the new one
      write_cfg(L1, H1, MODE_EXTRACT, 1'b0);
      cfg_low = X4;
      check_word("cfgwe beat7 word k", X5, 1'b0, 7);
      check_word("cfgwe beat7 word k+1", X5, 1'b1, -1);

      // cfg_we with the first beat: copy takes the pre-write shadow
      cfg_low = L1;
      check_word("cfgwe beat0 word k", X5, 1'b1, 0);
      check_word("cfgwe beat0 word k+1", X5, 1'b0, -1);

      // Back-to-back words, in_en held high through CMP with junk slices
      write_cfg(L1, H1, MODE_EXTRACT, 1'b0);
      exp_q.push_back(X8);
      exp_q.push_back(128'h9123_4567_89AB_CDEF_0011_2233_4455_6677);
      mon_en = 1'b1;
      send_beats(X8, 0, BEATS, -1);
      in_en = 1'b1; iot_in = 8'hFF; @(negedge clk);
      send_beats(128'h9123_4567_89AB_CDEF_0011_2233_4455_6677, 0, BEATS, -1);
      in_en = 1'b1; iot_in = 8'hFF; @(negedge clk);
      send_beats(128'h1000_0000_0000_0000_0000_0000_0000_0000, 0, BEATS, -1);
      in_en = 1'b1; iot_in = 8'hFF; @(negedge clk);
      in_en = 1'b0;
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      check("b2b valid count", (DATA_W+1)'(got_q.size()), (DATA_W+1)'(2));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         check("b2b word", {1'b0, got_q.pop_front()}, {1'b0, exp_q.pop_front()});
      end
      got_q.delete();
      exp_q.delete();

      // Reset at beat 5; config must return to the full-range default
      write_cfg(L1, H1, MODE_EXTRACT, 1'b1);
      send_beats(X8, 0, 5, -1);
      rst = 1'b1;
      #1;
      check("mid-word reset outputs", {busy, valid, iot_out}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("after reset idle", {busy, valid, iot_out}, '0);
      check_word("post-reset default pass", X5, 1'b1, -1);
      check_word("post-reset default excl high", ONES, 1'b0, -1);

`ifdef RANGE_FILTER_STATS_EN
      write_cfg(L1, H1, MODE_EXTRACT, 1'b0);
      check("stats cleared", {pass_cnt, drop_cnt, s_pass_cnt, s_drop_cnt}, '0);
      for (int i = 0; i < 10; i++) check_word("stats pass word", X8, 1'b1, -1);
      for (int i = 0; i < 6; i++)  check_word("stats drop word", X5, 1'b0, -1);
      check("pass_cnt", {1'b0, 112'h0, pass_cnt}, {1'b0, 112'h0, 16'd10});
      check("drop_cnt", {1'b0, 112'h0, drop_cnt}, {1'b0, 112'h0, 16'd6});
      check("sat pass_cnt", {1'b0, 126'h0, s_pass_cnt}, {1'b0, 126'h0, 2'd3});
      check("sat drop_cnt", {1'b0, 126'h0, s_drop_cnt}, {1'b0, 126'h0, 2'd3});
      write_cfg(L1, H1, MODE_EXTRACT, 1'b0);
      check("stats cleared by cfg_we", {pass_cnt, drop_cnt, s_pass_cnt, s_drop_cnt}, '0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
